// File: rtl/shift_univ_reg.sv
// Parametrised universal shift register: serial shift both ways, rotate, parallel load,
// synchronous clear, clock enable, cascade outputs and a registered word-complete pulse.
module shift_univ_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic             s_out_r,
  output logic             s_out_l,
  output logic             word_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] q_next;
  logic             wv_next;
  logic             shift_op;
  logic             cnt_clear;
  mode_e            mode_dec;

  assign mode_dec = mode_e'(mode);

  // Datapath: next register word and whether this op counts toward a serial word.
  always_comb begin
    q_next    = q_out;
    shift_op  = 1'b0;
    cnt_clear = 1'b0;
    if (en) begin
      case (mode_dec)
        MODE_SHR: begin
          q_next   = {s_in_r, q_out[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_SHL: begin
          q_next   = {q_out[WIDTH-2:0], s_in_l};
          shift_op = 1'b1;
        end
        MODE_ROR:  q_next = {q_out[0], q_out[WIDTH-1:1]};
        MODE_ROL:  q_next = {q_out[WIDTH-2:0], q_out[WIDTH-1]};
        MODE_LOAD: begin
          q_next    = d_in;
          cnt_clear = 1'b1;
        end
        MODE_CLR: begin
          q_next    = '0;
          cnt_clear = 1'b1;
        end
        default:   q_next = q_out;
      endcase
    end
  end

  // Word counter: the WIDTH-th serial shift wraps the count and raises the pulse.
  always_comb begin
    cnt_next = cnt;
    wv_next  = 1'b0;
    if (cnt_clear) begin
      cnt_next = '0;
    end else if (shift_op) begin
      if (cnt == CNT_LAST) begin
        cnt_next = '0;
        wv_next  = 1'b1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_out      <= RESET_VAL;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      q_out      <= q_next;
      cnt        <= cnt_next;
      word_valid <= wv_next;
    end
  end

  assign s_out_r = q_out[0];
  assign s_out_l = q_out[WIDTH-1];

endmodule

// File: tb/tb_shift_univ_reg.sv
// Directed bench for shift_univ_reg (WIDTH=8, RESET_VAL=8'hA5) with a reference model
// feeding an expected-value queue that is drained one clock after each stimulus step.
module tb_shift_univ_reg;

  localparam int W = 9;
  localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011,
                         ROL = 3'b100, LOAD = 3'b101, CLR = 3'b110, RSVD = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       s_in_r;
  logic       s_in_l;
  logic [7:0] d_in;
  logic [7:0] q_out;
  logic       s_out_r;
  logic       s_out_l;
  logic       word_valid;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  // Reference state: register, serial count, pending pulse.
  logic [7:0] m_q;
  int         m_cnt;
  logic       m_wv;

  shift_univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
    .d_in(d_in), .q_out(q_out), .s_out_r(s_out_r), .s_out_l(s_out_l),
    .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic e, input logic [2:0] m, input logic sr, input logic sl,
                            input logic [7:0] d);
    logic shifted;
    shifted = 1'b0;
    m_wv    = 1'b0;
    if (e) begin
      case (m)
        SHR:  begin m_q = {sr, m_q[7:1]}; shifted = 1'b1; end
        SHL:  begin m_q = {m_q[6:0], sl}; shifted = 1'b1; end
        ROR:  m_q = {m_q[0], m_q[7:1]};
        ROL:  m_q = {m_q[6:0], m_q[7]};
        LOAD: begin m_q = d; m_cnt = 0; end
        CLR:  begin m_q = 8'h00; m_cnt = 0; end
        default: ;
      endcase
      if (shifted) begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_wv  = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [2:0] m,
                      input logic sr, input logic sl, input logic [7:0] d);
    logic [W-1:0] exp;
    @(negedge clk);
    en = e; mode = m; s_in_r = sr; s_in_l = sl; d_in = d;
    model_step(e, m, sr, sl, d);
    exp_q.push_back({m_wv, m_q});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check({tag, ".q"},  32'(q_out),      32'(exp[7:0]));
    check({tag, ".wv"}, 32'(word_valid), 32'(exp[8]));
    check({tag, ".sr"}, 32'(s_out_r),    32'(exp[0]));
    check({tag, ".sl"}, 32'(s_out_l),    32'(exp[7]));
  endtask

  initial begin
    logic [7:0] bits;
    reset = 1'b1; en = 1'b0; mode = HOLD; s_in_r = 1'b0; s_in_l = 1'b0; d_in = 8'h00;
    m_q = 8'hA5; m_cnt = 0; m_wv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.q",  32'(q_out),      32'h A5);
    check("reset.wv", 32'(word_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: en low holds the reset value whatever the mode
    for (int i = 0; i < 5; i++) step("t1", 1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b1, 8'hFF);
    check("t1.q", 32'(q_out), 32'hA5);

    // 2: clear, then assemble a word by shifting right
    step("t2clr", 1'b1, CLR, 1'b0, 1'b0, 8'h00);
    bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) step("t2", 1'b1, SHR, bits[i], 1'b0, 8'h00);
    check("t2.q",  32'(q_out),      32'h4D);
    check("t2.wv", 32'(word_valid), 32'h1);
    step("t2hold", 1'b1, HOLD, 1'b0, 1'b0, 8'h00);

    // 3: load then rotate out and back
    step("t3ld", 1'b1, LOAD, 1'b0, 1'b0, 8'h81);
    for (int i = 0; i < 3; i++) step("t3rol", 1'b1, ROL, 1'b1, 1'b1, 8'h00);
    check("t3.rol", 32'(q_out), 32'h0C);
    for (int i = 0; i < 3; i++) step("t3ror", 1'b1, ROR, 1'b1, 1'b1, 8'h00);
    check("t3.ror", 32'(q_out), 32'h81);

    // 4: a load discards a partial word
    for (int i = 0; i < 5; i++) step("t4a", 1'b1, SHL, 1'b0, 1'b1, 8'h00);
    step("t4ld", 1'b1, LOAD, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step("t4b", 1'b1, SHL, 1'b0, 1'b1, 8'h00);
    check("t4.nowv", 32'(word_valid), 32'h0);
    step("t4c", 1'b1, SHL, 1'b0, 1'b1, 8'h00);
    check("t4.q",  32'(q_out),      32'hFF);
    check("t4.wv", 32'(word_valid), 32'h1);

    // 5: an enable gap does not disturb the count or the word
    for (int i = 0; i < 4; i++) step("t5a", 1'b1, SHR, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step("t5gap", 1'b0, SHR, 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 4; i++) step("t5b", 1'b1, SHR, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    check("t5.wv", 32'(word_valid), 32'h1);

    // 6: asynchronous reset mid-word
    for (int i = 0; i < 6; i++) step("t6a", 1'b1, SHR, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6.async.q",  32'(q_out),      32'hA5);
    check("t6.async.wv", 32'(word_valid), 32'h0);
    m_q = 8'hA5; m_cnt = 0; m_wv = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step("t6b", 1'b1, SHR, 1'b0, 1'b0, 8'h00);
    check("t6.nowv", 32'(word_valid), 32'h0);
    step("t6c", 1'b1, SHR, 1'b1, 1'b0, 8'h00);
    check("t6.wv", 32'(word_valid), 32'h1);
    step("t6rsvd", 1'b1, RSVD, 1'b1, 1'b1, 8'hFF);
    check("t6.rsvd", 32'(q_out), 32'h80);
    step("t6clr", 1'b1, CLR, 1'b1, 1'b1, 8'hFF);
    check("t6.clr", 32'(q_out), 32'h00);

    // Mixed random traffic against the model
    for (int i = 0; i < 60; i++)
      step("rnd", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    check("queue.empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
